regfile_rename: RTL and testbench

//  Architectural register file with rename tags. It sits between the decoder and the ROB:
//  - receives ROB commits and writes the architectural value;
//  - renames rd to the allocated ROB id at issue;
//  - resolves rs1/rs2 for the issuing instruction, either to a value or to a pending ROB id,
//    by querying the ROB search ports;
//  - drops every tag on a ROB clear (mispredict flush).

---
 rtl/regfile_rename_pkg.sv | 15 +
 rtl/regfile_operand_resolver.sv | 41 ++++
 rtl/regfile_rename.sv | 120 ++++++++++++
 tb/tb_regfile_rename.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_rename_pkg.sv
// Shared widths for the rename register file.
// Also holds the x0 test used by the operand resolver.
package regfile_rename_pkg;

  localparam int unsigned RobWidth = 3;
  localparam int unsigned RobSize  = 2 ** RobWidth;
  localparam int unsigned RegNum   = 32;
  localparam int unsigned RegIdxW  = 5;
  localparam int unsigned XLen     = 32;

  function automatic logic is_x0(input logic [RegIdxW-1:0] idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/regfile_operand_resolver.sv
// Resolves one source operand to a ready value or to the ROB id that will produce it.
// Purely combinational; one instance is used per source operand.
module regfile_operand_resolver
  import regfile_rename_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = RobWidth
) (
  input  logic [RegIdxW-1:0]   reg_idx,
  input  logic                 reg_busy,
  input  logic [ROB_WIDTH-1:0] reg_tag,
  input  logic [XLen-1:0]      reg_val,
  input  logic                 commit_ready,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [XLen-1:0]      commit_val,
  input  logic                 search_ready,
  input  logic [XLen-1:0]      search_val,
  output logic [XLen-1:0]      op_val,
  output logic                 op_has_dep,
  output logic [ROB_WIDTH-1:0] op_dep
);

  always_comb begin
    op_val     = '0;
    op_has_dep = 1'b0;
    op_dep     = '0;
    if (!is_x0(reg_idx)) begin
      // A commit landing this cycle beats the ROB search result for the same producer.
      if (commit_ready && reg_busy && (reg_tag == commit_rob_id)) begin
        op_val = commit_val;
      end else if (reg_busy && search_ready) begin
        op_val = search_val;
      end else if (reg_busy) begin
        op_has_dep = 1'b1;
        op_dep     = reg_tag;
      end else begin
        op_val = reg_val;
      end
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with rename tags between the decoder and the ROB.
// Commits write values, issue renames rd to its ROB id, clear drops every pending tag.
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = RobWidth,
  parameter int unsigned REG_NUM   = RegNum
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dec_ready,
  input  logic [RegIdxW-1:0]   dec_rs1,
  input  logic [RegIdxW-1:0]   dec_rs2,
  input  logic [RegIdxW-1:0]   dec_rd,
  input  logic                 dec_rd_write,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  output logic [XLen-1:0]      rs1_val,
  output logic                 rs1_has_dep,
  output logic [ROB_WIDTH-1:0] rs1_dep,
  output logic [XLen-1:0]      rs2_val,
  output logic                 rs2_has_dep,
  output logic [ROB_WIDTH-1:0] rs2_dep,
  output logic [ROB_WIDTH-1:0] search_rob_id_1,
  input  logic                 search_ready_1,
  input  logic [XLen-1:0]      search_val_1,
  output logic [ROB_WIDTH-1:0] search_rob_id_2,
  input  logic                 search_ready_2,
  input  logic [XLen-1:0]      search_val_2,
  input  logic                 commit_ready,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [RegIdxW-1:0]   commit_reg_id,
  input  logic [XLen-1:0]      commit_val
);

  logic [XLen-1:0]      val_q [REG_NUM];
  logic [XLen-1:0]      val_d [REG_NUM];
  logic [ROB_WIDTH-1:0] tag_q [REG_NUM];
  logic [ROB_WIDTH-1:0] tag_d [REG_NUM];
  logic [REG_NUM-1:0]   busy_q;
  logic [REG_NUM-1:0]   busy_d;

  logic commit_en;
  logic issue_en;

  assign commit_en = commit_ready && !is_x0(commit_reg_id);
  assign issue_en  = dec_ready && dec_rd_write && !is_x0(dec_rd);

  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_en) begin
      val_d[commit_reg_id] = commit_val;
      // A stale commit (tag already reassigned) only refreshes the value.
      if (busy_q[commit_reg_id] && (tag_q[commit_reg_id] == commit_rob_id)) begin
        busy_d[commit_reg_id] = 1'b0;
      end
    end
    if (clear) begin
      busy_d = '0;
    end else if (issue_en) begin
      busy_d[dec_rd] = 1'b1;
      tag_d[dec_rd]  = dec_rob_id;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < int'(REG_NUM); i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (rdy_in) begin
      busy_q <= busy_d;
      val_q  <= val_d;
      tag_q  <= tag_d;
    end
  end

  assign search_rob_id_1 = tag_q[dec_rs1];
  assign search_rob_id_2 = tag_q[dec_rs2];

  regfile_operand_resolver #(
    .ROB_WIDTH(ROB_WIDTH)
  ) u_rs1 (
    .reg_idx      (dec_rs1),
    .reg_busy     (busy_q[dec_rs1]),
    .reg_tag      (tag_q[dec_rs1]),
    .reg_val      (val_q[dec_rs1]),
    .commit_ready (commit_ready),
    .commit_rob_id(commit_rob_id),
    .commit_val   (commit_val),
    .search_ready (search_ready_1),
    .search_val   (search_val_1),
    .op_val       (rs1_val),
    .op_has_dep   (rs1_has_dep),
    .op_dep       (rs1_dep)
  );

  regfile_operand_resolver #(
    .ROB_WIDTH(ROB_WIDTH)
  ) u_rs2 (
    .reg_idx      (dec_rs2),
    .reg_busy     (busy_q[dec_rs2]),
    .reg_tag      (tag_q[dec_rs2]),
    .reg_val      (val_q[dec_rs2]),
    .commit_ready (commit_ready),
    .commit_rob_id(commit_rob_id),
    .commit_val   (commit_val),
    .search_ready (search_ready_2),
    .search_val   (search_val_2),
    .op_val       (rs2_val),
    .op_has_dep   (rs2_has_dep),
    .op_dep       (rs2_dep)
  );

endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename: a per-register model checked every cycle,
// plus literal expectations at the interesting points of the sequence.
module tb_regfile_rename;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, dec_ready, dec_rd_write;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, commit_reg_id;
  logic [2:0]  dec_rob_id, commit_rob_id;
  logic [31:0] rs1_val, rs2_val, search_val_1, search_val_2, commit_val;
  logic        rs1_has_dep, rs2_has_dep, search_ready_1, search_ready_2, commit_ready;
  logic [2:0]  rs1_dep, rs2_dep, search_rob_id_1, search_rob_id_2;

  regfile_rename #(
    .ROB_WIDTH(3),
    .REG_NUM  (32)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clear          (clear),
    .dec_ready      (dec_ready),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .dec_rd_write   (dec_rd_write),
    .dec_rob_id     (dec_rob_id),
    .rs1_val        (rs1_val),
    .rs1_has_dep    (rs1_has_dep),
    .rs1_dep        (rs1_dep),
    .rs2_val        (rs2_val),
    .rs2_has_dep    (rs2_has_dep),
    .rs2_dep        (rs2_dep),
    .search_rob_id_1(search_rob_id_1),
    .search_ready_1 (search_ready_1),
    .search_val_1   (search_val_1),
    .search_rob_id_2(search_rob_id_2),
    .search_ready_2 (search_ready_2),
    .search_val_2   (search_val_2),
    .commit_ready   (commit_ready),
    .commit_rob_id  (commit_rob_id),
    .commit_reg_id  (commit_reg_id),
    .commit_val     (commit_val)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: architectural value plus "pending on ROB id" per register.
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [2:0]  m_tag  [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_op(input int r, input logic sr, input logic [31:0] sv,
                           output logic [31:0] v, output logic d, output logic [2:0] t);
    v = 32'h0; d = 1'b0; t = 3'h0;
    if (r == 0) v = 32'h0;
    else if (commit_ready && m_busy[r] && m_tag[r] == commit_rob_id) v = commit_val;
    else if (m_busy[r] && sr) v = sv;
    else if (m_busy[r]) begin d = 1'b1; t = m_tag[r]; end
    else v = m_val[r];
  endtask

  task automatic model_update();
    bit          clr_busy;
    int          cr, rd;
    cr = int'(commit_reg_id);
    rd = int'(dec_rd);
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'h0; m_busy[i] = 1'b0; m_tag[i] = 3'h0;
      end
    end else if (rdy_in) begin
      clr_busy = commit_ready && cr != 0 && m_busy[cr] && m_tag[cr] == commit_rob_id;
      if (commit_ready && cr != 0) m_val[cr] = commit_val;
      if (clr_busy) m_busy[cr] = 1'b0;
      if (clear) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (dec_ready && dec_rd_write && rd != 0) begin
        m_busy[rd] = 1'b1;
        m_tag[rd]  = dec_rob_id;
      end
    end
  endtask

  always @(negedge clk_in) begin
    logic [31:0] ev;
    logic        ed;
    logic [2:0]  et;
    if (chk_en) begin
      expect_op(int'(dec_rs1), search_ready_1, search_val_1, ev, ed, et);
      chk("rs1_val", rs1_val, ev);
      chk("rs1_has_dep", {31'h0, rs1_has_dep}, {31'h0, ed});
      if (ed) chk("rs1_dep", {29'h0, rs1_dep}, {29'h0, et});
      chk("search_rob_id_1", {29'h0, search_rob_id_1}, {29'h0, m_tag[dec_rs1]});
      expect_op(int'(dec_rs2), search_ready_2, search_val_2, ev, ed, et);
      chk("rs2_val", rs2_val, ev);
      chk("rs2_has_dep", {31'h0, rs2_has_dep}, {31'h0, ed});
      if (ed) chk("rs2_dep", {29'h0, rs2_dep}, {29'h0, et});
      chk("search_rob_id_2", {29'h0, search_rob_id_2}, {29'h0, m_tag[dec_rs2]});
    end
  end

  task automatic set_defaults();
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    dec_ready = 1'b0; dec_rd_write = 1'b0; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
    dec_rd = 5'd0; dec_rob_id = 3'd0;
    search_ready_1 = 1'b0; search_val_1 = 32'h0;
    search_ready_2 = 1'b0; search_val_2 = 32'h0;
    commit_ready = 1'b0; commit_rob_id = 3'd0; commit_reg_id = 5'd0; commit_val = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_update();
    #1;
    set_defaults();
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] rob);
    dec_ready = 1'b1; dec_rd_write = 1'b1; dec_rd = rd; dec_rob_id = rob;
  endtask

  task automatic commit(input logic [2:0] rob, input logic [4:0] rg, input logic [31:0] v);
    commit_ready = 1'b1; commit_rob_id = rob; commit_reg_id = rg; commit_val = v;
  endtask

  initial begin
    set_defaults();
    rst_in = 1'b1;
    @(posedge clk_in);
    model_update();
    #1;
    chk_en = 1'b1;
    rst_in = 1'b1;
    tick();

    // Reset state.
    dec_rs1 = 5'd5; dec_rs2 = 5'd0; #3;
    chk("lit_reset_rs1_val", rs1_val, 32'h0);
    chk("lit_reset_rs1_dep", {31'h0, rs1_has_dep}, 32'h0);
    chk("lit_reset_rs2_val", rs2_val, 32'h0);
    chk("lit_reset_rs2_dep", {31'h0, rs2_has_dep}, 32'h0);
    tick();

    issue(5'd5, 3'd3); tick();
    dec_rs1 = 5'd5; dec_rs2 = 5'd5; search_ready_2 = 1'b1; search_val_2 = 32'hBEEF; #3;
    chk("lit_rename_search_id", {29'h0, search_rob_id_1}, 32'd3);
    chk("lit_rename_has_dep", {31'h0, rs1_has_dep}, 32'd1);
    chk("lit_rename_dep", {29'h0, rs1_dep}, 32'd3);
    chk("lit_search_bypass", rs2_val, 32'hBEEF);
    tick();

    commit(3'd3, 5'd5, 32'h1234); dec_rs1 = 5'd5; #3;
    chk("lit_commit_bypass", rs1_val, 32'h1234);
    chk("lit_commit_bypass_dep", {31'h0, rs1_has_dep}, 32'd0);
    tick();
    dec_rs1 = 5'd5; #3;
    chk("lit_after_commit", rs1_val, 32'h1234);
    chk("lit_after_commit_dep", {31'h0, rs1_has_dep}, 32'd0);
    tick();

    // Stale commit keeps the newer tag.
    issue(5'd5, 3'd3); tick();
    issue(5'd5, 3'd6); tick();
    commit(3'd3, 5'd5, 32'hA); dec_rs1 = 5'd5; tick();
    dec_rs1 = 5'd5; #3;
    chk("lit_stale_has_dep", {31'h0, rs1_has_dep}, 32'd1);
    chk("lit_stale_dep", {29'h0, rs1_dep}, 32'd6);
    tick();

    // Issue and commit on x7 in one cycle.
    issue(5'd7, 3'd1); tick();
    issue(5'd7, 3'd2); commit(3'd1, 5'd7, 32'h55); tick();
    dec_rs1 = 5'd7; #3;
    chk("lit_same_cycle_dep", {29'h0, rs1_dep}, 32'd2);
    chk("lit_same_cycle_has_dep", {31'h0, rs1_has_dep}, 32'd1);
    tick();

    // Clear with a concurrent issue.
    commit(3'd0, 5'd1, 32'h11); tick();
    commit(3'd0, 5'd2, 32'h22); tick();
    issue(5'd1, 3'd4); tick();
    issue(5'd2, 3'd5); tick();
    dec_rs1 = 5'd1; dec_rs2 = 5'd2; #3;
    chk("lit_pre_clear_dep2", {29'h0, rs2_dep}, 32'd5);
    tick();
    clear = 1'b1; issue(5'd9, 3'd7); tick();
    dec_rs1 = 5'd1; dec_rs2 = 5'd2; #3;
    chk("lit_clear_x1", rs1_val, 32'h11);
    chk("lit_clear_x2", rs2_val, 32'h22);
    chk("lit_clear_x2_dep", {31'h0, rs2_has_dep}, 32'd0);
    tick();
    dec_rs1 = 5'd9; dec_rs2 = 5'd5; #3;
    chk("lit_clear_x9", {31'h0, rs1_has_dep}, 32'd0);
    chk("lit_stale_val_x5", rs2_val, 32'hA);
    tick();
    dec_rs1 = 5'd7; #3;
    chk("lit_same_cycle_val", rs1_val, 32'h55);
    tick();

    // x0 stays zero.
    commit(3'd0, 5'd0, 32'hFFFF); tick();
    dec_rs1 = 5'd0; #3;
    chk("lit_x0", rs1_val, 32'h0);
    tick();

    // Paused: nothing changes.
    rdy_in = 1'b0; issue(5'd3, 3'd1); commit(3'd0, 5'd4, 32'h44); tick();
    dec_rs1 = 5'd3; dec_rs2 = 5'd4; #3;
    chk("lit_pause_x3", {31'h0, rs1_has_dep}, 32'd0);
    chk("lit_pause_x4", rs2_val, 32'h0);
    tick();

    // Mixed traffic on x0..x7, checked by the model only.
    for (int i = 0; i < 24; i++) begin
      dec_rs1 = 5'(i * 3 % 8); dec_rs2 = 5'((i + 2) % 8);
      if (i % 3 != 2) issue(5'(i * 5 % 8), 3'(i % 8));
      if (i % 2 == 1) commit(3'((i + 5) % 8), 5'(i * 7 % 8), 32'(i * 32'h101));
      search_ready_1 = (i % 4 == 1); search_val_1 = 32'(i + 32'h900);
      search_ready_2 = (i % 5 == 3); search_val_2 = 32'(i + 32'h700);
      clear  = (i == 17);
      rdy_in = (i != 9);
      tick();
    end

    // Reset wins over clear and issue.
    rst_in = 1'b1; clear = 1'b1; issue(5'd5, 3'd4); tick();
    dec_rs1 = 5'd5; #3;
    chk("lit_final_reset", rs1_val, 32'h0);
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
